noc_credit_tx: RTL and testbench
================================

# noc_credit_tx

Credit-based transmitter for one mesh link: the sending end of a router input port. It accepts payload and destination from a local source, builds the packet header with destination and source coordinates, and buffers packets in a small queue. It drives a valid/ready link into the downstream router and never exceeds the downstream FIFO's capacity, tracking that capacity with a credit counter replenished by returned credit pulses. One instance sits between each core or network interface and its router's local input, or on any router output feeding a neighbour.

## Interface
Parameters:
- PACKET_WIDTH, 128, total packet width
- FIFO_DEPTH, 8, downstream input-FIFO depth; initial and maximum credit count
- COORD_W, 4, width of each coordinate field
- QUEUE_DEPTH, 4, local packet queue entries (power of 2, ≥2)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, in, 1, clock
  - rst, in, 1, synchronous active-high reset
- cur_x / cur_y, in, COORD_W each, this node's coordinates, stamped as source
- link_up, in, 1, downstream link usable
- src_valid, in, 1, source offers a packet
- src_dst_x / src_dst_y, in, COORD_W each, destination coordinates
- src_payload, in, PACKET_WIDTH-4*COORD_W, payload
- src_ready, out, 1, queue can accept
- tx_valid, out, 1, packet offered to downstream router
- tx_packet, out, PACKET_WIDTH, packet
- tx_ready, in, 1, downstream accepts
- credit_in, in, 1, one-cycle pulse: downstream freed one FIFO slot
- credit_count, out, $clog2(FIFO_DEPTH+1), current credits
- credit_err, out, 1, sticky: credit returned while counter already full

## Operation
- Packet format, MSB first: dst_x, dst_y, src_x, src_y (COORD_W each), then payload in the low PACKET_WIDTH-4*COORD_W bits. The header is captured at enqueue. cur_x/cur_y are sampled at enqueue time.
- Queue: circular buffer, QUEUE_DEPTH entries, with wrapping read and write pointers plus an occupancy count of width $clog2(QUEUE_DEPTH+1).
  - src_ready = !full, independent of link state and credits.
  - Enqueue when src_valid && src_ready.
  - There is no bypass: a full queue accepts nothing, even when a dequeue occurs in the same cycle.
- State machine, two states:
  - DOWN: tx_valid = 0. credit_count is forced to FIFO_DEPTH every cycle. The queue is retained and enqueue is still allowed. Go to UP when link_up = 1.
  - UP: tx_valid = !empty && credit_count != 0. tx_packet = queue head. Go to DOWN when link_up = 0; the transition takes effect next cycle, and no transfer is counted in the cycle link_up is low.
- Transfer: tx_valid && tx_ready, in UP with link_up = 1. A transfer dequeues the head and consumes one credit.
- Credit arithmetic:
  - Next count = count − send + credit_in.
  - Send and credit_in in the same cycle leaves the count unchanged.
  - credit_in while count == FIFO_DEPTH with no send: the count holds at FIFO_DEPTH and credit_err is set. credit_err clears only on rst.
  - Count never underflows, because a send requires count ≥ 1.
- Once tx_valid is asserted, tx_packet stays stable and tx_valid stays high until the transfer completes or link_up drops.

## Timing
- Reset values:
  - state = DOWN
  - queue empty, both pointers 0
  - credit_count = FIFO_DEPTH
  - tx_valid = 0, src_ready = 1, credit_err = 0
  - tx_packet = 0, because queue storage is cleared on reset
- Reset asserted mid-operation discards queued packets and abandons any offered packet in the next cycle.
- Latency:
  - A packet enqueued at cycle N can present on tx_valid at N+1 at the earliest, given UP and credits > 0.
  - A credit pulse at cycle N is visible in credit_count at N+1, so a stalled tx_valid can rise at N+1.
  - link_up rising at N: state is UP at N+1, and tx_valid can be high at N+1.
- Throughput: one packet per cycle while credits > 0, tx_ready = 1 and the queue is non-empty.
- credit_count and credit_err are registered outputs. tx_valid and src_ready are derived combinationally from registered state only; neither depends combinationally on tx_ready or src_valid.

## Test plan
- Reset, link_up = 1, enqueue one packet with dst = (3,2), cur = (1,0), payload 0xABCD, tx_ready = 1:
  - tx_valid at the next cycle
  - tx_packet[127:112] = 0x3210, low bits = 0xABCD
  - credit_count goes 8 → 7
- Enqueue 10 packets back-to-back, tx_ready = 1, no credits returned:
  - exactly 8 transfers, then tx_valid = 0 with queue non-empty and credit_count = 0
  - one credit_in pulse → exactly one more transfer next cycle
- tx_ready = 0 for 5 cycles with a packet offered: tx_valid and tx_packet remain stable, credit_count unchanged. Fill the queue: src_ready = 0 at 4 entries with no overflow.
- credit_in in the same cycle as a transfer: credit_count unchanged. credit_in at count = 8 with no send: count stays 8 and credit_err rises and stays high.
- With credits at 3 and 2 packets queued, drop link_up for 3 cycles:
  - tx_valid = 0 and credit_count = 8 while down
  - on re-up, both packets are sent in order
- Assert rst with 3 packets queued: queue empty, credit_count = 8, tx_valid = 0 in the next cycle.

Source files
------------

// File: rtl/noc_credit_tx_if.sv
// Source-side and link-side handshake bundle for noc_credit_tx.
interface noc_credit_tx_if #(
    parameter int unsigned PACKET_WIDTH = 128,
    parameter int unsigned COORD_W      = 4
);
    localparam int unsigned PAYLOAD_W = PACKET_WIDTH - 4 * COORD_W;

    logic                    src_valid;
    logic [COORD_W-1:0]      src_dst_x;
    logic [COORD_W-1:0]      src_dst_y;
    logic [PAYLOAD_W-1:0]    src_payload;
    logic                    src_ready;
    logic                    tx_valid;
    logic [PACKET_WIDTH-1:0] tx_packet;
    logic                    tx_ready;
    logic                    credit_in;

    // Transmitter side
    modport master (
        input  src_valid, src_dst_x, src_dst_y, src_payload, tx_ready, credit_in,
        output src_ready, tx_valid, tx_packet
    );

    // Local source and downstream router side
    modport slave (
        output src_valid, src_dst_x, src_dst_y, src_payload, tx_ready, credit_in,
        input  src_ready, tx_valid, tx_packet
    );
endinterface

// File: rtl/noc_credit_tx.sv
// Credit-based mesh link transmitter: header stamping, local packet queue,
// credit tracking of the downstream input FIFO.
module noc_credit_tx #(
    parameter int unsigned PACKET_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned COORD_W      = 4,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [COORD_W-1:0]                cur_x,
    input  logic [COORD_W-1:0]                cur_y,
    input  logic                              link_up,
    noc_credit_tx_if.master                   bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   credit_count,
    output logic                              credit_err
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [PACKET_WIDTH-1:0] mem_q [QUEUE_DEPTH];
    logic [PACKET_WIDTH-1:0] mem_d [QUEUE_DEPTH];
    logic [CNT_W-1:0]        credit_q, credit_d;
    logic                    err_q, err_d;

    logic full;
    logic empty;
    logic tx_valid_w;
    logic send;
    logic enq;

    assign full  = (occ_q == OCC_W'(QUEUE_DEPTH));
    assign empty = (occ_q == '0);

    assign bus.src_ready = !full;
    assign bus.tx_valid  = tx_valid_w;
    assign bus.tx_packet = mem_q[rd_ptr_q];
    assign credit_count  = credit_q;
    assign credit_err    = err_q;

    // Link state, queue bookkeeping and credit arithmetic
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        mem_d      = mem_q;
        credit_d   = credit_q;
        err_d      = err_q;
        tx_valid_w = 1'b0;

        case (state_q)
            ST_DOWN: begin
                if (link_up) state_d = ST_UP;
            end
            ST_UP: begin
                tx_valid_w = !empty && (credit_q != '0);
                if (!link_up) state_d = ST_DOWN;
            end
            default: state_d = ST_DOWN;
        endcase

        // A drop of link_up cancels the transfer in that same cycle
        send = tx_valid_w && bus.tx_ready && link_up;
        enq  = bus.src_valid && !full;

        if (enq) begin
            mem_d[wr_ptr_q] = {bus.src_dst_x, bus.src_dst_y, cur_x, cur_y, bus.src_payload};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (send) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(enq) - OCC_W'(send);

        // Leaving or staying down restores the full downstream capacity
        if ((state_q == ST_DOWN) || !link_up) begin
            credit_d = CNT_W'(FIFO_DEPTH);
        end else if (bus.credit_in && !send && (credit_q == CNT_W'(FIFO_DEPTH))) begin
            err_d = 1'b1;
        end else begin
            credit_d = credit_q - CNT_W'(send) + CNT_W'(bus.credit_in);
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_DOWN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            credit_q <= CNT_W'(FIFO_DEPTH);
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            credit_q <= credit_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_noc_credit_tx.sv
// Randomized and directed bench for noc_credit_tx against a queue-based model.
module tb_noc_credit_tx;
    localparam int unsigned PW  = 128;
    localparam int unsigned CW  = 4;
    localparam int unsigned FD  = 8;
    localparam int unsigned QD  = 4;
    localparam int unsigned PLW = PW - 4 * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cur_x, cur_y;
    logic          link_up;
    logic [3:0]    credit_count;
    logic          credit_err;

    noc_credit_tx_if #(.PACKET_WIDTH(PW), .COORD_W(CW)) bus ();

    noc_credit_tx #(.PACKET_WIDTH(PW), .FIFO_DEPTH(FD), .COORD_W(CW), .QUEUE_DEPTH(QD)) dut (
        .clk          (clk),
        .rst          (rst),
        .cur_x        (cur_x),
        .cur_y        (cur_y),
        .link_up      (link_up),
        .bus          (bus.master),
        .credit_count (credit_count),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_xfer = 0;
    int n_enq = 0;

    // Reference model: packet queue, credit integer, sticky error, link state
    logic [PW-1:0] mq [$];
    int            m_cred;
    bit            m_err;
    bit            m_up;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cred = FD;
        m_err  = 1'b0;
        m_up   = 1'b0;
    endtask

    // Inputs are already applied; compare, advance the model, move to next cycle
    task automatic cycle();
        bit exp_v, s, e;
        #1;
        exp_v = m_up && (mq.size() != 0) && (m_cred != 0);
        check("src_ready", PW'(bus.src_ready), PW'(mq.size() < QD));
        check("tx_valid", PW'(bus.tx_valid), PW'(exp_v));
        if (exp_v) check("tx_packet", bus.tx_packet, mq[0]);
        check("credit_count", PW'(credit_count), PW'(m_cred));
        check("credit_err", PW'(credit_err), PW'(m_err));
        if (bus.tx_valid && bus.tx_ready && link_up) n_xfer++;
        s = exp_v && bus.tx_ready && link_up;
        e = bus.src_valid && (mq.size() < QD);
        if (e) n_enq++;
        if (rst) begin
            model_reset();
        end else begin
            if (s) void'(mq.pop_front());
            if (e) mq.push_back({bus.src_dst_x, bus.src_dst_y, cur_x, cur_y, bus.src_payload});
            if (!m_up || !link_up) m_cred = FD;
            else if (bus.credit_in && !s && m_cred == FD) m_err = 1'b1;
            else m_cred = m_cred - int'(s) + int'(bus.credit_in);
            m_up = link_up;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_xfer = 0;
        n_enq  = 0;
    endtask

    task automatic rand_src();
        bus.src_dst_x   = CW'($urandom());
        bus.src_dst_y   = CW'($urandom());
        bus.src_payload = PLW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    initial begin
        logic [PW-1:0] cap;
        int            base;

        rst = 1'b1; link_up = 1'b0; cur_x = '0; cur_y = '0;
        bus.src_valid = 1'b0; bus.src_dst_x = '0; bus.src_dst_y = '0; bus.src_payload = '0;
        bus.tx_ready = 1'b0; bus.credit_in = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check("reset_tx_packet", bus.tx_packet, '0);
        check("reset_src_ready", PW'(bus.src_ready), PW'(1));
        rst = 1'b0;

        // Single packet with a known header
        cur_x = 4'd1; cur_y = 4'd0; link_up = 1'b1; bus.tx_ready = 1'b1;
        bus.src_valid = 1'b1; bus.src_dst_x = 4'd3; bus.src_dst_y = 4'd2;
        bus.src_payload = PLW'(16'hABCD);
        cycle();
        bus.src_valid = 1'b0;
        #1;
        check("first_valid", PW'(bus.tx_valid), PW'(1));
        check("first_header", PW'(bus.tx_packet[PW-1 -: 16]), PW'(16'h3210));
        check("first_payload", PW'(bus.tx_packet[PLW-1:0]), PW'(16'hABCD));
        cycle();
        check("first_credit", PW'(credit_count), PW'(7));

        // Ten packets, no credit return: exactly eight go out
        do_reset();
        for (int i = 0; i < 30; i++) begin
            bus.src_valid = (n_enq < 10);
            rand_src();
            cycle();
        end
        bus.src_valid = 1'b0;
        check("burst_xfers", PW'(n_xfer), PW'(8));
        check("burst_stalled", PW'(bus.tx_valid), PW'(0));
        check("burst_credit", PW'(credit_count), PW'(0));
        bus.credit_in = 1'b1;
        cycle();
        bus.credit_in = 1'b0;
        repeat (3) cycle();
        check("one_credit_xfer", PW'(n_xfer), PW'(9));

        // Backpressure stall then queue fill
        bus.tx_ready = 1'b0;
        bus.credit_in = 1'b1;
        cycle();
        bus.credit_in = 1'b0;
        cap = bus.tx_packet;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_valid", PW'(bus.tx_valid), PW'(1));
            check("stall_packet", bus.tx_packet, cap);
            check("stall_credit", PW'(credit_count), PW'(1));
        end
        bus.src_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_src();
            cycle();
        end
        bus.src_valid = 1'b0;
        check("full_src_ready", PW'(bus.src_ready), PW'(0));

        // Credit return alongside sends, then overflow at full count
        bus.tx_ready = 1'b1; bus.credit_in = 1'b1;
        cycle();
        check("send_and_credit", PW'(credit_count), PW'(1));
        repeat (13) cycle();
        check("overflow_count", PW'(credit_count), PW'(FD));
        check("overflow_err", PW'(credit_err), PW'(1));
        bus.credit_in = 1'b0;
        repeat (3) cycle();
        check("err_sticky", PW'(credit_err), PW'(1));

        // Link drop with three credits and two packets pending
        do_reset();
        bus.src_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_src();
            cycle();
        end
        bus.src_valid = 1'b0;
        repeat (2) cycle();
        check("pre_drop_credit", PW'(credit_count), PW'(3));
        bus.tx_ready = 1'b0; bus.src_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_src();
            cycle();
        end
        bus.src_valid = 1'b0; bus.tx_ready = 1'b1; link_up = 1'b0;
        base = n_xfer;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("down_valid", PW'(bus.tx_valid), PW'(0));
            check("down_credit", PW'(credit_count), PW'(FD));
        end
        link_up = 1'b1;
        repeat (4) cycle();
        check("reup_xfers", PW'(n_xfer - base), PW'(2));

        // Reset with three packets queued
        bus.tx_ready = 1'b0; bus.src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_src();
            cycle();
        end
        bus.src_valid = 1'b0;
        do_reset();
        check("rst_valid", PW'(bus.tx_valid), PW'(0));
        check("rst_credit", PW'(credit_count), PW'(FD));
        check("rst_src_ready", PW'(bus.src_ready), PW'(1));
        check("rst_packet", bus.tx_packet, '0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            link_up       = ($urandom_range(0, 19) != 0);
            bus.tx_ready  = ($urandom_range(0, 9) < 7);
            bus.src_valid = ($urandom_range(0, 9) < 6);
            bus.credit_in = ($urandom_range(0, 9) < 3);
            cur_x         = CW'($urandom());
            cur_y         = CW'($urandom());
            rand_src();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
